// File: rtl/darksocv_rstseq_pkg.sv
// Shared types for the darksocv staged reset sequencer: FSM states and
// reset-cause codes reported on CAUSE.
package darksocv_rstseq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_REL  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_RES = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

endpackage

// File: rtl/darksocv_rstseq_if.sv
// Request/status bundle of the reset sequencer. The master drives the
// soft-reset requests and the watchdog kick; the slave drives the reset outputs and the status.
interface darksocv_rstseq_if #(
  parameter int NCH = 4
);
  logic           SWRES;
  logic [NCH-1:0] CHRES;
  logic           HBEAT;
  logic [NCH-1:0] RSTO;
  logic           READY;
  logic           BUSY;
  logic [1:0]     CAUSE;

  modport master (
    output SWRES, CHRES, HBEAT,
    input  RSTO, READY, BUSY, CAUSE
  );

  modport slave (
    input  SWRES, CHRES, HBEAT,
    output RSTO, READY, BUSY, CAUSE
  );
endinterface

// File: rtl/darksocv_rstch.sv
// Per-channel soft-reset hold timer. A start request loads a down-counter.
// The channel stays in reset until the counter has expired.
module darksocv_rstch #(
  parameter int HOLD = 16,
  parameter int CW   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic clear_i,
  output logic rst_d_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    if (clear_i) begin
      cnt_d = '0;
      act_d = 1'b0;
    end else if (start_i) begin
      cnt_d = CW'(HOLD - 1);
      act_d = 1'b1;
    end else if (act_q) begin
      if (cnt_q == '0) begin
        act_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // The parent registers RSTO from this next-cycle value, so a request shows on the very next edge.
  assign rst_d_o = act_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/darksocv_rstseq.sv
// Staged multi-channel reset sequencer for darksocv. Optional watchdog
// restart is compiled in with DARKSOCV_RSTSEQ_WDT_EN.
//
// state   | meaning
// HOLD    | all outputs in reset, counting HOLD cycles
// REL     | releasing channels in order, one every STAGGER cycles
// RUN     | sequence done, per-channel soft resets accepted
module darksocv_rstseq
  import darksocv_rstseq_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int HOLD       = 16,
  parameter int STAGGER    = 4,
  parameter int CW         = 16,
  parameter int WDT_CYCLES = 65535
) (
  input  logic CLK,
  input  logic RES,
  darksocv_rstseq_if.slave bus
);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("darksocv_rstseq: NCH must be in 1..32");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("darksocv_rstseq: HOLD must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("darksocv_rstseq: STAGGER must be >= 1");
  end
  if (64'(HOLD) > (64'd1 << CW) || 64'((NCH - 1) * STAGGER) >= (64'd1 << CW))
  begin : g_bad_cw
    $error("darksocv_rstseq: CW too narrow for HOLD/STAGGER");
  end
  if (WDT_CYCLES < 1 || 64'(WDT_CYCLES) > (64'd1 << (CW + 1))) begin : g_bad_wdt
    $error("darksocv_rstseq: WDT_CYCLES out of range");
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     idx_q, idx_d;
  logic [NCH-1:0] rsto_q, rsto_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [1:0]     cause_q, cause_d;
  logic [NCH-1:0] ch_start, ch_rst_d;
  logic           ch_clear;
  logic           wdt_fire;

`ifdef DARKSOCV_RSTSEQ_WDT_EN
  logic [CW:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d    = '0;
    wdt_fire = 1'b0;
    if (state_q == ST_RUN && !bus.SWRES && !bus.HBEAT) begin
      if (wdt_q == (CW + 1)'(WDT_CYCLES - 1)) begin
        wdt_fire = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_hbeat;
  assign unused_hbeat = bus.HBEAT;
  assign wdt_fire     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rsto_d   = rsto_q;
    cause_d  = cause_q;
    ch_clear = 1'b0;
    ch_start = '0;
    if (bus.SWRES || wdt_fire) begin
      state_d  = ST_HOLD;
      cnt_d    = '0;
      idx_d    = '0;
      rsto_d   = '1;
      ch_clear = 1'b1;
      cause_d  = bus.SWRES ? CAUSE_SW : CAUSE_WDT;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == CW'(HOLD - 1)) begin
            state_d   = ST_REL;
            cnt_d     = '0;
            idx_d     = '0;
            rsto_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_REL: begin
          if (idx_q == 5'(NCH - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q == CW'(STAGGER - 1)) begin
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
            for (int k = 0; k < NCH; k++) begin
              if (k == int'(idx_q) + 1) rsto_d[k] = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          ch_start = bus.CHRES;
          rsto_d   = ch_rst_d;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          rsto_d  = '1;
        end
      endcase
    end
    ready_d = (state_d == ST_RUN) && (rsto_d == '0);
    busy_d  = (state_d != ST_RUN);
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    darksocv_rstch #(
      .HOLD (HOLD),
      .CW   (CW)
    ) u_ch (
      .clk     (CLK),
      .rst     (RES),
      .start_i (ch_start[k]),
      .clear_i (ch_clear),
      .rst_d_o (ch_rst_d[k])
    );
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rsto_q  <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_RES;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rsto_q  <= rsto_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign bus.RSTO  = rsto_q;
  assign bus.READY = ready_q;
  assign bus.BUSY  = busy_q;
  assign bus.CAUSE = cause_q;

endmodule

// File: tb/tb_darksocv_rstseq.sv
// Bench for darksocv_rstseq: a time-stamp model (edges since last full reset
// and since each channel request) checked every cycle, plus literal checkpoints.
module tb_darksocv_rstseq;

  localparam int NCH     = 4;
  localparam int HOLD    = 16;
  localparam int STAGGER = 4;
  localparam int CW      = 16;
`ifdef DARKSOCV_RSTSEQ_WDT_EN
  localparam int WDT     = 100;
`else
  localparam int WDT     = 65535;
`endif
  localparam int T_RUN   = HOLD + (NCH - 1) * STAGGER + 1;
  localparam int NEVER   = -1000000;

  logic CLK;
  logic RES;

  darksocv_rstseq_if #(.NCH(NCH)) bus ();

  darksocv_rstseq #(
    .NCH        (NCH),
    .HOLD       (HOLD),
    .STAGGER    (STAGGER),
    .CW         (CW),
    .WDT_CYCLES (WDT)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: edge of last full reset, edge of last accepted request per channel,
  // edge at which the watchdog count was last zero, and the last cause.
  int         edge_n = 0;
  int         seq_e  = 0;
  int         wref   = 0;
  int         lc [NCH];
  logic [1:0] cause_m = 2'd0;

  initial begin
    for (int k = 0; k < NCH; k++) lc[k] = NEVER;
  end

  always @(posedge CLK) begin
    int e;
    bit run_prev;
    bit fire;
    edge_n++;
    e        = edge_n;
    run_prev = ((e - 1) - seq_e) >= T_RUN;
    fire     = 1'b0;
`ifdef DARKSOCV_RSTSEQ_WDT_EN
    fire = run_prev && !bus.HBEAT && (((e - 1) - wref) == WDT - 1);
`endif
    if (RES) begin
      seq_e   = e;
      cause_m = 2'd0;
      for (int k = 0; k < NCH; k++) lc[k] = NEVER;
    end else if (bus.SWRES || fire) begin
      seq_e   = e;
      cause_m = bus.SWRES ? 2'd1 : 2'd2;
      for (int k = 0; k < NCH; k++) lc[k] = NEVER;
    end else if (run_prev) begin
      for (int k = 0; k < NCH; k++) if (bus.CHRES[k]) lc[k] = e;
      if (bus.HBEAT) wref = e;
    end
    if (e - seq_e == T_RUN) wref = e;
  end

  always @(negedge CLK) begin
    int n;
    bit run;
    logic [NCH-1:0] er;
    if (edge_n > 0) begin
      n  = edge_n - seq_e;
      run = (n >= T_RUN);
      for (int k = 0; k < NCH; k++) begin
        er[k] = run ? ((edge_n - lc[k]) < HOLD) : (n < HOLD + k * STAGGER);
      end
      chk("model_rsto",  32'(bus.RSTO),  32'(er));
      chk("model_ready", 32'(bus.READY), 32'(run && (er == '0)));
      chk("model_busy",  32'(bus.BUSY),  32'(!run));
      chk("model_cause", 32'(bus.CAUSE), 32'(cause_m));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RES       = 1'b1;
    bus.SWRES = 1'b0;
    bus.CHRES = '0;
    bus.HBEAT = 1'b0;

    // Power-on: RES for 5 edges, then the 16/20/24/28 release ladder.
    step(5);
    chk("res_rsto", 32'(bus.RSTO), 32'h0F);
    chk("res_busy", 32'(bus.BUSY), 32'h1);
    RES = 1'b0;
    step(15);
    chk("t1_e15", 32'(bus.RSTO), 32'h0F);
    step(1);
    chk("t1_e16", 32'(bus.RSTO), 32'h0E);
    step(4);
    chk("t1_e20", 32'(bus.RSTO), 32'h0C);
    step(4);
    chk("t1_e24", 32'(bus.RSTO), 32'h08);
    step(4);
    chk("t1_e28", 32'(bus.RSTO), 32'h00);
    chk("t1_e28_ready", 32'(bus.READY), 32'h0);
    step(1);
    chk("t1_e29_ready", 32'(bus.READY), 32'h1);
    chk("t1_e29_busy",  32'(bus.BUSY),  32'h0);
    chk("t1_cause",     32'(bus.CAUSE), 32'h0);

    // Software restart from RUN.
    step(3);
    bus.SWRES = 1'b1;
    step(1);
    bus.SWRES = 1'b0;
    chk("t2_rsto",  32'(bus.RSTO),  32'h0F);
    chk("t2_cause", 32'(bus.CAUSE), 32'h1);
    chk("t2_busy",  32'(bus.BUSY),  32'h1);
    step(15);
    chk("t2_e15", 32'(bus.RSTO), 32'h0F);
    step(1);
    chk("t2_e16", 32'(bus.RSTO), 32'h0E);
    step(12);
    chk("t2_e28", 32'(bus.RSTO), 32'h00);
    step(1);
    chk("t2_ready", 32'(bus.READY), 32'h1);

    // Channel 2 soft reset, then a re-pulse that extends the hold.
    step(2);
    bus.CHRES = 4'b0100;
    step(1);
    bus.CHRES = '0;
    chk("t3_on",       32'(bus.RSTO),  32'h04);
    chk("t3_on_ready", 32'(bus.READY), 32'h0);
    step(15);
    chk("t3_c15", 32'(bus.RSTO), 32'h04);
    step(1);
    chk("t3_c16",       32'(bus.RSTO),  32'h00);
    chk("t3_c16_ready", 32'(bus.READY), 32'h1);
    step(2);
    bus.CHRES = 4'b0100;
    step(1);
    bus.CHRES = '0;
    step(7);
    bus.CHRES = 4'b0100;
    step(1);
    bus.CHRES = '0;
    step(15);
    chk("t3_c23", 32'(bus.RSTO), 32'h04);
    step(1);
    chk("t3_c24", 32'(bus.RSTO), 32'h00);

    // CHRES and SWRES together: the full sequence wins, no leftover hold.
    step(2);
    bus.CHRES = 4'b0010;
    bus.SWRES = 1'b1;
    step(1);
    bus.CHRES = '0;
    bus.SWRES = 1'b0;
    chk("t4_rsto",  32'(bus.RSTO),  32'h0F);
    chk("t4_cause", 32'(bus.CAUSE), 32'h1);
    step(29);
    chk("t4_ready", 32'(bus.READY), 32'h1);
    chk("t4_rsto0", 32'(bus.RSTO),  32'h00);

    // RES in the middle of REL.
    bus.SWRES = 1'b1;
    step(1);
    bus.SWRES = 1'b0;
    step(21);
    chk("t5_mid", 32'(bus.RSTO), 32'h0C);
    RES = 1'b1;
    step(1);
    RES = 1'b0;
    chk("t5_rsto",  32'(bus.RSTO),  32'h0F);
    chk("t5_cause", 32'(bus.CAUSE), 32'h0);
    chk("t5_busy",  32'(bus.BUSY),  32'h1);
    step(16);
    chk("t5_e16", 32'(bus.RSTO), 32'h0E);
    step(13);
    chk("t5_ready", 32'(bus.READY), 32'h1);

`ifdef DARKSOCV_RSTSEQ_WDT_EN
    // Watchdog: 100 RUN cycles without a kick, then kicks every 50.
    step(99);
    chk("t6_pre_busy", 32'(bus.BUSY), 32'h0);
    step(1);
    chk("t6_busy",  32'(bus.BUSY),  32'h1);
    chk("t6_cause", 32'(bus.CAUSE), 32'h2);
    step(29);
    chk("t6_ready", 32'(bus.READY), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step(49);
      bus.HBEAT = 1'b1;
      step(1);
      bus.HBEAT = 1'b0;
    end
    chk("t6_kick_busy",  32'(bus.BUSY),  32'h0);
    chk("t6_kick_cause", 32'(bus.CAUSE), 32'h2);
`endif

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.CHRES = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : '0;
      bus.SWRES = ($urandom_range(0, 199) == 0);
      bus.HBEAT = ($urandom_range(0, 39) == 0);
      RES       = ($urandom_range(0, 499) == 0);
      step(1);
    end
    RES       = 1'b0;
    bus.SWRES = 1'b0;
    bus.CHRES = '0;
    bus.HBEAT = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
